mux_4_1_rr_arb: RTL and testbench
=================================

# mux_4_1_rr_arb

Round-robin arbiter and output register for a 4:1 selection datapath. Four requesters each present a WIDTH-bit word with a valid/ready handshake. The block picks one requester per cycle using a rotating priority pointer and steers that word through an internal 4-entry array-indexed mux into a single registered output channel. It sits between independent producers and one shared consumer, replacing a statically driven `sel` with a fair, flow-controlled grant.

## Interface
- WIDTH, 4, data width of every requester word and of the output word
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_vld  in  4  bit i = requester i presents a valid word
- req_data0, req_data1, req_data2, req_data3  in  WIDTH  requester words
- req_rdy  out  4  bit i = word i is accepted this cycle; one-hot or zero
- out_vld  out  1  output register holds a word
- out_data  out  WIDTH  registered selected word
- out_sel  out  2  index of the requester that supplied out_data
- out_rdy  in  1  consumer accepts the word this cycle

## Operation
- Handshake rules:
  - A transfer occurs on any channel when vld && rdy are both high at a rising edge.
  - A requester must hold vld and data stable until it sees rdy.
  - The consumer may raise or drop out_rdy freely.
- State: output register is EMPTY (out_vld=0) or FULL (out_vld=1).
- Load enable: load_ok = !out_vld || out_rdy.
- Arbitration is combinational:
  - Scan req_vld starting at index ptr, in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first set bit is the winner g.
  - req_rdy = onehot(g) when load_ok and any req_vld is set; otherwise 4'b0000.
- On a load (any req_rdy bit set):
  - out_data <= req_data[g] via the array-indexed mux.
  - out_sel <= g.
  - out_vld <= 1.
  - ptr <= g+1 mod 4.
- Output consumed (out_vld && out_rdy) with no request: out_vld <= 0. out_data and out_sel hold their last values.
- Stall (out_vld && !out_rdy):
  - out_vld, out_data, out_sel and ptr hold.
  - req_rdy = 0.
- ptr updates only on a load. Idle cycles do not rotate it.
- Pointer wrap: g=3 gives ptr=0.
- Arithmetic is 2-bit modulo-4 on ptr and on the scan index. The data path does not modify the word.
- Fairness: with all four requesters continuously valid and out_rdy=1, the grant order is ptr, ptr+1, ... and each requester gets exactly 1 of every 4 transfers.

## Timing
- Reset values (asynchronous, immediate on rst=1):
  - out_vld=0, out_data=0, out_sel=0, ptr=0.
  - req_rdy=0 while rst=1.
- Latency: a word accepted at edge N appears on out_data/out_vld right after edge N (visible in cycle N+1).
- Throughput: one word per cycle while out_rdy=1.
- req_rdy is a combinational function of req_vld, ptr, out_vld and out_rdy. There is a combinational path out_rdy -> req_rdy, and it is intentional.
- Simultaneous consume and load in the same cycle: the old word leaves, the new word loads, and out_vld stays 1 with no bubble.
- Reset mid-operation: any word held in the output register is discarded and no handshake completes on the reset cycle. After rst falls, the first grant starts from index 0.
- A requester that drops req_vld before being granted is simply skipped. No state is kept per requester.

## Test plan
- Reset check:
  - Stimulus: assert rst with out_vld=1 and ptr=2.
  - Required: out_vld=0, out_data=0, out_sel=0 and req_rdy=0 immediately. After release, req_vld=4'b1111 grants req 0 first.
- Rotation:
  - Stimulus: req_vld=4'b1111, data0..3=4'hA,4'hB,4'hC,4'hD, out_rdy=1 for 8 cycles.
  - Required: out_data sequence A,B,C,D,A,B,C,D; out_sel sequence 0,1,2,3,0,1,2,3; ptr wraps 3 to 0.
- Sparse requests:
  - Stimulus: req_vld=4'b1010 with ptr=0.
  - Required: grant order 1,3,1,3.
  - Then from ptr=2 with only req 0 valid: grant 0 and ptr becomes 1.
- Backpressure:
  - Stimulus: out_rdy=0 for 3 cycles while out_vld=1 and out_data=4'h5.
  - Required: out_data, out_sel and out_vld stable and req_rdy=0. On the cycle out_rdy=1, the next winner loads back-to-back with no empty cycle.
- Drain:
  - Stimulus: single word from req 2 (4'h7), then req_vld=0 with out_rdy=1.
  - Required: out_vld=1 for exactly one cycle with out_data=7 and out_sel=2, then out_vld=0. ptr=3 holds through idle cycles.
- Random soak:
  - Stimulus: random req_vld, data and out_rdy for 10k cycles.
  - Required:
    - The scoreboard sees every accepted word exactly once, in acceptance order.
    - req_rdy is always one-hot or zero.
    - No requester waits more than 4 loads while it stays valid.

Source files
------------

// File: rtl/mux_4_1_rr_arb_if.sv
// ---------------------------------------------------------------------------
// mux_4_1_rr_arb_if
// Bundle of the four requester channels and the single output channel of the
// round-robin 4:1 arbiter.
//
//   req_vld    [3:0]       bit i = requester i presents a valid word
//   req_data0..3 [WIDTH]   requester words
//   req_rdy    [3:0]       bit i = word i accepted this cycle (one-hot/zero)
//   out_vld                output register holds a word
//   out_data   [WIDTH]     registered selected word
//   out_sel    [1:0]       requester index that supplied out_data
//   out_rdy                consumer accepts the word this cycle
//
// Modports:
//   slave  - arbiter side (consumes requests, produces the output channel)
//   master - environment side (producers and consumer)
// ---------------------------------------------------------------------------
interface mux_4_1_rr_arb_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req_vld;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [WIDTH-1:0] req_data2;
  logic [WIDTH-1:0] req_data3;
  logic [3:0]       req_rdy;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_rdy;

  modport slave (
    input  req_vld,
    input  req_data0,
    input  req_data1,
    input  req_data2,
    input  req_data3,
    output req_rdy,
    output out_vld,
    output out_data,
    output out_sel,
    input  out_rdy
  );

  modport master (
    output req_vld,
    output req_data0,
    output req_data1,
    output req_data2,
    output req_data3,
    input  req_rdy,
    input  out_vld,
    input  out_data,
    input  out_sel,
    output out_rdy
  );
endinterface

// File: rtl/mux_4_1_rr_arb.sv
// ---------------------------------------------------------------------------
// mux_4_1_rr_arb
// Round-robin arbiter feeding a single registered output channel. Each cycle
// the first valid requester found when scanning from the rotating pointer is
// granted (if the output register can take a word); its word is steered
// through a 4-entry array-indexed mux into the output register.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - mux_4_1_rr_arb_if.slave: req_vld/req_data0..3/req_rdy requester
//          channels, out_vld/out_data/out_sel/out_rdy output channel
//
// req_rdy is combinational from req_vld, the pointer, out_vld and out_rdy;
// the out_rdy -> req_rdy path is deliberate so a consumed word can be
// replaced in the same cycle without a bubble.
// ---------------------------------------------------------------------------
module mux_4_1_rr_arb #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_4_1_rr_arb_if.slave       bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [1:0]       sel_q,   sel_d;

  logic [WIDTH-1:0] req_data_a [4];
  logic             load_ok;
  logic             any_vld;
  logic             load;
  logic [1:0]       grant;

  // Scan position: 2-bit add wraps naturally modulo 4.
  function automatic logic [1:0] scan_idx(input logic [1:0] base,
                                          input logic [1:0] offs);
    return base + offs;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign req_data_a[0] = bus.req_data0;
  assign req_data_a[1] = bus.req_data1;
  assign req_data_a[2] = bus.req_data2;
  assign req_data_a[3] = bus.req_data3;

  // Arbitration: walk the scan order backwards so the last write is the
  // first valid requester at or after ptr_q.
  always_comb begin
    logic [1:0] idx;
    idx   = 2'd0;
    grant = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = scan_idx(ptr_q, 2'(k));
      if (bus.req_vld[idx]) begin
        grant = idx;
      end
    end
  end

  assign any_vld = |bus.req_vld;
  assign load_ok = (state_q == EMPTY) || bus.out_rdy;
  // No handshake may complete while reset is held.
  assign load    = load_ok && any_vld && !rst;

  assign bus.req_rdy = load ? onehot4(grant) : 4'b0000;

  // Next-state logic for the output register occupancy and pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = FULL;
          data_d  = req_data_a[grant];
          sel_d   = grant;
          ptr_d   = grant + 2'd1;
        end
      end
      FULL: begin
        if (load) begin
          // Consume and reload in the same cycle: stay FULL, no bubble.
          data_d = req_data_a[grant];
          sel_d  = grant;
          ptr_d  = grant + 2'd1;
        end else if (bus.out_rdy) begin
          // Word leaves with nothing to replace it; data/sel keep last value.
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Register stage: output word, its source index and the priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.out_vld  = (state_q == FULL);
  assign bus.out_data = data_q;
  assign bus.out_sel  = sel_q;

endmodule

// File: tb/tb_mux_4_1_rr_arb.sv
module tb_mux_4_1_rr_arb;
  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  mux_4_1_rr_arb_if #(.WIDTH(WIDTH)) bus ();

  mux_4_1_rr_arb #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       sel;
  } sb_t;

  sb_t              sb [$];
  logic [1:0]       m_ptr;
  logic             m_vld;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       m_sel;
  int               wc [4];

  // Rotate the request vector so position 0 is the pointer, take the lowest
  // set bit, and translate back to a requester index.
  function automatic logic [1:0] model_winner(input logic [1:0] p, input logic [3:0] v);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] j;
    dbl = {v, v};
    rot = 4'(dbl >> p);
    j   = 2'd0;
    for (int b = 3; b >= 0; b--) if (rot[b]) j = 2'(b);
    return p + j;
  endfunction

  function automatic logic [WIDTH-1:0] pick(input logic [1:0] g);
    case (g)
      2'd0: return bus.req_data0;
      2'd1: return bus.req_data1;
      2'd2: return bus.req_data2;
      default: return bus.req_data3;
    endcase
  endfunction

  function automatic logic model_load();
    return (!m_vld || bus.out_rdy) && (|bus.req_vld);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr  <= 2'd0;
      m_vld  <= 1'b0;
      m_data <= '0;
      m_sel  <= 2'd0;
      sb.delete();
      for (int i = 0; i < 4; i++) wc[i] <= 0;
    end else begin
      if (bus.out_vld && bus.out_rdy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got word %0h with no accepted word pending", bus.out_data);
        end else begin
          chk("sb_data", 32'(bus.out_data), 32'(sb[0].data));
          chk("sb_sel",  32'(bus.out_sel),  32'(sb[0].sel));
          sb.pop_front();
        end
      end
      if (model_load()) begin
        sb.push_back('{data: pick(model_winner(m_ptr, bus.req_vld)),
                       sel:  model_winner(m_ptr, bus.req_vld)});
        m_data <= pick(model_winner(m_ptr, bus.req_vld));
        m_sel  <= model_winner(m_ptr, bus.req_vld);
        m_vld  <= 1'b1;
        m_ptr  <= model_winner(m_ptr, bus.req_vld) + 2'd1;
        for (int i = 0; i < 4; i++) begin
          if (!bus.req_vld[i] || (2'(i) == model_winner(m_ptr, bus.req_vld))) begin
            wc[i] <= 0;
          end else begin
            chk("starvation_bound", 32'(wc[i] + 1 <= 4), 32'd1);
            wc[i] <= wc[i] + 1;
          end
        end
      end else begin
        if (m_vld && bus.out_rdy) m_vld <= 1'b0;
        for (int i = 0; i < 4; i++) if (!bus.req_vld[i]) wc[i] <= 0;
      end
    end
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_rdy_model", 32'(bus.req_rdy),
          model_load() ? 32'(4'b0001 << model_winner(m_ptr, bus.req_vld)) : 32'd0);
      chk("rdy_onehot0", 32'($onehot0(bus.req_rdy)), 32'd1);
      chk("out_vld_model", 32'(bus.out_vld), 32'(m_vld));
      chk("out_data_model", 32'(bus.out_data), 32'(m_data));
      chk("out_sel_model", 32'(bus.out_sel), 32'(m_sel));
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  vld;
    logic [15:0] data;   // {d3,d2,d1,d0}
    logic        ordy;
    logic [3:0]  erdy;
    logic        evld;
    logic [3:0]  edata;
    logic [1:0]  esel;
  } vec_t;

  vec_t vec [$];

  task automatic add(input logic [3:0] v, input logic [15:0] d, input logic o,
                     input logic [3:0] er, input logic ev, input logic [3:0] ed,
                     input logic [1:0] es);
    vec.push_back('{vld: v, data: d, ordy: o, erdy: er, evld: ev, edata: ed, esel: es});
  endtask

  task automatic apply(input logic [3:0] v, input logic [15:0] d, input logic o);
    bus.req_vld   = v;
    bus.req_data0 = d[3:0];
    bus.req_data1 = d[7:4];
    bus.req_data2 = d[11:8];
    bus.req_data3 = d[15:12];
    bus.out_rdy   = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rotation: all valid, grants 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 2; r++) begin
      add(4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
      add(4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
      add(4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2);
      add(4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);
    end
    // Sparse 1010 from ptr=0: 1,3,1,3.
    add(4'b1010, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
    add(4'b1010, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);
    add(4'b1010, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
    add(4'b1010, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);
    // Move ptr to 2, then only req 0 valid -> grant 0, ptr becomes 1.
    add(4'b0010, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
    add(4'b0001, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
    add(4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
    // Backpressure: load 5 from req 2, stall 3 cycles, then req 3 back-to-back.
    add(4'b0100, 16'hD5BA, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2);
    add(4'b1111, 16'hD5BA, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2);
    add(4'b1111, 16'hD5BA, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2);
    add(4'b1111, 16'hD5BA, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2);
    add(4'b1111, 16'hD5BA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);
    // Drain: single word 7 from req 2, then idle; ptr stays 3.
    add(4'b0100, 16'hD7BA, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2);
    add(4'b0000, 16'hD7BA, 1'b1, 4'b0000, 1'b0, 4'h7, 2'd2);
    add(4'b0000, 16'hD7BA, 1'b1, 4'b0000, 1'b0, 4'h7, 2'd2);
    add(4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);

    // Power-on reset.
    rst = 1'b1;
    apply(4'b0000, 16'h0000, 1'b0);
    tick();
    tick();
    chk("por_out_vld",  32'(bus.out_vld),  32'd0);
    chk("por_out_data", 32'(bus.out_data), 32'd0);
    chk("por_out_sel",  32'(bus.out_sel),  32'd0);
    chk("por_req_rdy",  32'(bus.req_rdy),  32'd0);
    rst = 1'b0;

    foreach (vec[i]) begin
      apply(vec[i].vld, vec[i].data, vec[i].ordy);
      #1;
      chk($sformatf("vec%0d_req_rdy", i), 32'(bus.req_rdy), 32'(vec[i].erdy));
      tick();
      chk($sformatf("vec%0d_out_vld", i),  32'(bus.out_vld),  32'(vec[i].evld));
      chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vec[i].edata));
      chk($sformatf("vec%0d_out_sel", i),  32'(bus.out_sel),  32'(vec[i].esel));
    end

    // Reset mid-operation with a word held and ptr=2.
    apply(4'b0010, 16'hDCBA, 1'b1);
    tick();
    chk("pre_rst_out_vld", 32'(bus.out_vld), 32'd1);
    chk("pre_rst_out_sel", 32'(bus.out_sel), 32'd1);
    apply(4'b0000, 16'hDCBA, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_vld",  32'(bus.out_vld),  32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_sel",  32'(bus.out_sel),  32'd0);
    apply(4'b1111, 16'hDCBA, 1'b1);
    #1;
    chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    tick();
    chk("rst_hold_out_vld", 32'(bus.out_vld), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_rdy", 32'(bus.req_rdy), 32'b0001);
    tick();
    chk("post_rst_out_sel",  32'(bus.out_sel),  32'd0);
    chk("post_rst_out_data", 32'(bus.out_data), 32'hA);

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      apply(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end

    // Drain and confirm every accepted word was delivered.
    apply(4'b0000, 16'h0000, 1'b1);
    tick();
    tick();
    tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_out_vld",  32'(bus.out_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
